mmio_fifo_csr: RTL and testbench

- Parametrised MMIO register block for the AFU. Sits behind the CCI-P wrapper, driven by the decoded c0 MMIO request fields. Drives the c2 MMIO response fields.
- Provides the mandatory DFH/AFU_ID registers, a scratch register, and a host-accessible FIFO.
- Host pushes by writing to a push address and pops by reading a pop address; status and overflow/underflow reporting are included.
- Supersedes the single-register MMIO AFU and its ad-hoc FIFO hookup.

---
 rtl/afu_mmio_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/mmio_fifo_csr.sv | 132 +++++++++++++
 tb/tb_mmio_fifo_csr.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/afu_mmio_pkg.sv
// Shared address map, DFH constant, STATUS/CTRL bit positions and the
// response record used by the AFU MMIO register block.
package afu_mmio_pkg;

    localparam logic [15:0] ADDR_DFH      = 16'h0000;
    localparam logic [15:0] ADDR_AFU_ID_L = 16'h0002;
    localparam logic [15:0] ADDR_AFU_ID_H = 16'h0004;
    localparam logic [15:0] ADDR_RSVD0    = 16'h0006;
    localparam logic [15:0] ADDR_RSVD1    = 16'h0008;

    // User register offsets from BASE_ADDR, in 32-bit word units
    localparam logic [15:0] OFF_SCRATCH   = 16'h0000;
    localparam logic [15:0] OFF_FIFO_DATA = 16'h0002;
    localparam logic [15:0] OFF_STATUS    = 16'h0004;
    localparam logic [15:0] OFF_CTRL      = 16'h0006;

    localparam logic [63:0] DFH_VALUE =
        {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

    localparam int STS_COUNT_LSB = 0;
    localparam int STS_EMPTY     = 16;
    localparam int STS_FULL      = 17;
    localparam int STS_OVERFLOW  = 18;
    localparam int STS_UNDERFLOW = 19;
    localparam int STS_DEPTH_LSB = 32;

    localparam int CTRL_FLUSH     = 0;
    localparam int CTRL_CLR_STICKY = 1;

    typedef struct packed {
        logic        valid;
        logic [8:0]  tid;
        logic [63:0] data;
    } t_mmio_rsp;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock register-array FIFO with flush; head is presented
// combinationally from storage so a pop can return it in the same cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    input  logic [DATA_WIDTH-1:0]       din_i,
    output logic [DATA_WIDTH-1:0]       dout_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    // Full/empty are judged on pre-edge state, so push+pop on a full FIFO drops the push
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mmio_fifo_csr.sv
// AFU MMIO register block: DFH/AFU_ID, scratch, host-accessible FIFO with
// status and sticky overflow/underflow, single-cycle registered read response.
module mmio_fifo_csr
    import afu_mmio_pkg::*;
#(
    parameter int           DATA_WIDTH = 64,
    parameter int           DEPTH      = 8,
    parameter logic [127:0] AFU_ID     = 128'h0,
    parameter logic [15:0]  BASE_ADDR  = 16'h0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_wr_valid,
    input  logic        mmio_rd_valid,
    input  logic [15:0] mmio_addr,
    input  logic [8:0]  mmio_tid,
    input  logic [63:0] mmio_wr_data,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data,
    output logic        fifo_not_empty,
    output logic        fifo_full
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [15:0] A_SCRATCH = BASE_ADDR + OFF_SCRATCH;
    localparam logic [15:0] A_FIFO    = BASE_ADDR + OFF_FIFO_DATA;
    localparam logic [15:0] A_STATUS  = BASE_ADDR + OFF_STATUS;
    localparam logic [15:0] A_CTRL    = BASE_ADDR + OFF_CTRL;

    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full_w, fifo_empty_w;
    logic                  push, pop, ctrl_wr, flush, clr_sticky;
    logic                  ovf_set, unf_set;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [63:0]           scratch_q, scratch_d;
    logic [63:0]           status_word;
    logic [63:0]           head_word;
    logic [63:0]           rd_data;
    t_mmio_rsp             rsp_q, rsp_d;

    assign push       = mmio_wr_valid && (mmio_addr == A_FIFO);
    assign pop        = mmio_rd_valid && (mmio_addr == A_FIFO);
    assign ctrl_wr    = mmio_wr_valid && (mmio_addr == A_CTRL);
    assign flush      = ctrl_wr && mmio_wr_data[CTRL_FLUSH];
    assign clr_sticky = ctrl_wr && mmio_wr_data[CTRL_CLR_STICKY];
    assign ovf_set    = push && fifo_full_w;
    assign unf_set    = pop && fifo_empty_w;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (mmio_wr_data[DATA_WIDTH-1:0]),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty_w)
    );

    // A same-cycle set beats a clear so no event is ever lost
    always_comb begin
        overflow_d  = ovf_set ? 1'b1 : (clr_sticky ? 1'b0 : overflow_q);
        underflow_d = unf_set ? 1'b1 : (clr_sticky ? 1'b0 : underflow_q);
        scratch_d   = (mmio_wr_valid && (mmio_addr == A_SCRATCH)) ? mmio_wr_data : scratch_q;
    end

    always_comb begin
        status_word                                  = '0;
        status_word[STS_COUNT_LSB +: 16]             = 16'(fifo_count);
        status_word[STS_EMPTY]                       = fifo_empty_w;
        status_word[STS_FULL]                        = fifo_full_w;
        status_word[STS_OVERFLOW]                    = overflow_q;
        status_word[STS_UNDERFLOW]                   = underflow_q;
        status_word[STS_DEPTH_LSB +: 32]             = 32'(DEPTH);
        head_word                                    = '0;
        if (!fifo_empty_w) head_word[DATA_WIDTH-1:0] = fifo_dout;
    end

    always_comb begin
        case (mmio_addr)
            ADDR_DFH:      rd_data = DFH_VALUE;
            ADDR_AFU_ID_L: rd_data = AFU_ID[63:0];
            ADDR_AFU_ID_H: rd_data = AFU_ID[127:64];
            ADDR_RSVD0:    rd_data = '0;
            ADDR_RSVD1:    rd_data = '0;
            A_SCRATCH:     rd_data = scratch_q;
            A_FIFO:        rd_data = head_word;
            A_STATUS:      rd_data = status_word;
            default:       rd_data = '0;
        endcase
    end

    // TID and data hold between responses; only valid pulses
    always_comb begin
        rsp_d       = rsp_q;
        rsp_d.valid = mmio_rd_valid;
        if (mmio_rd_valid) begin
            rsp_d.tid  = mmio_tid;
            rsp_d.data = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            scratch_q   <= '0;
            rsp_q       <= '0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            scratch_q   <= scratch_d;
            rsp_q       <= rsp_d;
        end
    end

    assign rsp_valid      = rsp_q.valid;
    assign rsp_tid        = rsp_q.tid;
    assign rsp_data       = rsp_q.data;
    assign fifo_not_empty = !fifo_empty_w;
    assign fifo_full      = fifo_full_w;

endmodule

// File: tb/tb_mmio_fifo_csr.sv
// Directed bench for mmio_fifo_csr: a vector table for single transactions
// plus hand-written sequences for simultaneous push/pop, flush and reset.
module tb_mmio_fifo_csr;

    localparam logic [127:0] TB_AFU_ID = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [63:0]  DFH       = 64'h1000_0100_0000_0000;
    localparam logic [15:0]  A_SCR     = 16'h0020;
    localparam logic [15:0]  A_FIFO    = 16'h0022;
    localparam logic [15:0]  A_STS     = 16'h0024;
    localparam logic [15:0]  A_CTRL    = 16'h0026;

    logic        clk = 1'b0;
    logic        rst;
    logic        mmio_wr_valid, mmio_rd_valid;
    logic [15:0] mmio_addr;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wr_data;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        fifo_not_empty, fifo_full;

    int checks = 0;
    int errors = 0;

    mmio_fifo_csr #(
        .DATA_WIDTH (64),
        .DEPTH      (8),
        .AFU_ID     (TB_AFU_ID),
        .BASE_ADDR  (16'h0020)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mmio_wr_valid  (mmio_wr_valid),
        .mmio_rd_valid  (mmio_rd_valid),
        .mmio_addr      (mmio_addr),
        .mmio_tid       (mmio_tid),
        .mmio_wr_data   (mmio_wr_data),
        .rsp_valid      (rsp_valid),
        .rsp_tid        (rsp_tid),
        .rsp_data       (rsp_data),
        .fifo_not_empty (fifo_not_empty),
        .fifo_full      (fifo_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp;
        logic        ne;
        logic        full;
    } vec_t;

    vec_t vq[$];
    logic cur_ne   = 1'b0;
    logic cur_full = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic wr, input logic rd, input logic [15:0] a,
                           input logic [63:0] d, input logic [63:0] e);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d; v.exp = e;
        v.ne = cur_ne; v.full = cur_full;
        vq.push_back(v);
    endtask

    task automatic add_rd(input logic [15:0] a, input logic [63:0] e);
        add_vec(1'b0, 1'b1, a, 64'h0, e);
    endtask

    task automatic add_wr(input logic [15:0] a, input logic [63:0] d, input logic ne, input logic full);
        cur_ne = ne; cur_full = full;
        add_vec(1'b1, 1'b0, a, d, 64'h0);
    endtask

    task automatic add_push(input logic [63:0] d, input logic ne, input logic full);
        add_wr(A_FIFO, d, ne, full);
    endtask

    task automatic add_pop(input logic [63:0] e, input logic ne, input logic full);
        cur_ne = ne; cur_full = full;
        add_rd(A_FIFO, e);
    endtask

    // Called at a negedge; returns at the following negedge with inputs idle
    task automatic xact(input logic wr, input logic rd, input logic [15:0] a,
                        input logic [63:0] d, input logic [8:0] t);
        mmio_wr_valid = wr;
        mmio_rd_valid = rd;
        mmio_addr     = a;
        mmio_wr_data  = d;
        mmio_tid      = t;
        @(posedge clk);
        @(negedge clk);
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
        mmio_addr     = 16'h0;
        mmio_wr_data  = 64'h0;
        mmio_tid      = 9'h0;
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a, input logic [63:0] e);
        xact(1'b0, 1'b1, a, 64'h0, 9'h1A);
        chk({nm, ".valid"}, 64'(rsp_valid), 64'h1);
        chk({nm, ".data"}, rsp_data, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
        mmio_addr     = 16'h0;
        mmio_tid      = 9'h0;
        mmio_wr_data  = 64'h0;

        // Table: register map, scratch, fill/overflow, drain/underflow, wrap
        add_rd(16'h0002, TB_AFU_ID[63:0]);
        add_rd(16'h0004, TB_AFU_ID[127:64]);
        add_rd(16'h0006, 64'h0);
        add_rd(16'h0008, 64'h0);
        add_rd(A_STS, 64'h0000_0008_0001_0000);
        add_wr(A_SCR, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0);
        add_rd(A_SCR, 64'hDEAD_BEEF_CAFE_F00D);
        add_wr(16'h0040, 64'h1234, 1'b0, 1'b0);
        add_rd(16'h0040, 64'h0);
        add_rd(A_SCR, 64'hDEAD_BEEF_CAFE_F00D);
        add_rd(A_CTRL, 64'h0);
        for (int k = 0; k < 8; k++) add_push(64'hA1 + 64'(k), 1'b1, k == 7);
        add_rd(A_STS, 64'h0000_0008_0002_0008);
        add_push(64'hA9, 1'b1, 1'b1);
        add_rd(A_STS, 64'h0000_0008_0006_0008);
        for (int k = 0; k < 8; k++) add_pop(64'hA1 + 64'(k), k < 7, 1'b0);
        add_pop(64'h0, 1'b0, 1'b0);
        add_rd(A_STS, 64'h0000_0008_000D_0000);
        add_wr(A_CTRL, 64'h2, 1'b0, 1'b0);
        add_rd(A_STS, 64'h0000_0008_0001_0000);
        for (int k = 0; k < 5; k++) add_push(64'hB1 + 64'(k), 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) add_pop(64'hB1 + 64'(k), k < 4, 1'b0);
        for (int k = 0; k < 8; k++) add_push(64'hC1 + 64'(k), 1'b1, k == 7);
        for (int k = 0; k < 8; k++) add_pop(64'hC1 + 64'(k), k < 7, 1'b0);
        add_rd(A_STS, 64'h0000_0008_0001_0000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.rsp_valid", 64'(rsp_valid), 64'h0);
        chk("reset.rsp_data", rsp_data, 64'h0);
        chk("reset.rsp_tid", 64'(rsp_tid), 64'h0);
        chk("reset.not_empty", 64'(fifo_not_empty), 64'h0);
        chk("reset.full", 64'(fifo_full), 64'h0);
        rst = 1'b0;

        xact(1'b0, 1'b1, 16'h0000, 64'h0, 9'h05);
        chk("dfh.valid", 64'(rsp_valid), 64'h1);
        chk("dfh.tid", 64'(rsp_tid), 64'h05);
        chk("dfh.data", rsp_data, DFH);
        @(negedge clk);
        chk("dfh.pulse", 64'(rsp_valid), 64'h0);
        chk("dfh.hold", rsp_data, DFH);

        for (int i = 0; i < vq.size(); i++) begin
            xact(vq[i].wr, vq[i].rd, vq[i].addr, vq[i].wdata, 9'(i));
            chk($sformatf("vec%0d.rsp_valid", i), 64'(rsp_valid), 64'(vq[i].rd));
            if (vq[i].rd) begin
                chk($sformatf("vec%0d.tid", i), 64'(rsp_tid), 64'(9'(i)));
                chk($sformatf("vec%0d.data", i), rsp_data, vq[i].exp);
            end
            chk($sformatf("vec%0d.not_empty", i), 64'(fifo_not_empty), 64'(vq[i].ne));
            chk($sformatf("vec%0d.full", i), 64'(fifo_full), 64'(vq[i].full));
        end

        // Push and pop together on an empty FIFO: pop underflows, push lands
        xact(1'b1, 1'b1, A_FIFO, 64'h77, 9'h11);
        chk("pp_empty.valid", 64'(rsp_valid), 64'h1);
        chk("pp_empty.data", rsp_data, 64'h0);
        chk("pp_empty.not_empty", 64'(fifo_not_empty), 64'h1);
        rd_chk("pp_empty.status", A_STS, 64'h0000_0008_0008_0001);
        rd_chk("pp_empty.pop", A_FIFO, 64'h77);
        chk("pp_empty.drained", 64'(fifo_not_empty), 64'h0);

        // Push and pop together on a full FIFO: pop succeeds, push dropped
        xact(1'b1, 1'b0, A_CTRL, 64'h2, 9'h0);
        for (int k = 0; k < 8; k++) xact(1'b1, 1'b0, A_FIFO, 64'hD1 + 64'(k), 9'h0);
        chk("pp_full.pre_full", 64'(fifo_full), 64'h1);
        xact(1'b1, 1'b1, A_FIFO, 64'hEE, 9'h12);
        chk("pp_full.data", rsp_data, 64'hD1);
        chk("pp_full.full", 64'(fifo_full), 64'h0);
        rd_chk("pp_full.status", A_STS, 64'h0000_0008_0004_0007);

        // Flush alone keeps sticky flags; flush+clear drops both
        xact(1'b1, 1'b0, A_CTRL, 64'h1, 9'h0);
        chk("flush.not_empty", 64'(fifo_not_empty), 64'h0);
        rd_chk("flush.status", A_STS, 64'h0000_0008_0005_0000);
        for (int k = 0; k < 3; k++) xact(1'b1, 1'b0, A_FIFO, 64'hE1 + 64'(k), 9'h0);
        chk("ctrl3.pre_ne", 64'(fifo_not_empty), 64'h1);
        xact(1'b1, 1'b0, A_CTRL, 64'h3, 9'h0);
        chk("ctrl3.not_empty", 64'(fifo_not_empty), 64'h0);
        rd_chk("ctrl3.status", A_STS, 64'h0000_0008_0001_0000);
        xact(1'b1, 1'b0, A_FIFO, 64'hF1, 9'h0);
        rd_chk("ctrl3.pop_after", A_FIFO, 64'hF1);

        // Read accepted in the reset cycle gives no response
        xact(1'b1, 1'b0, A_FIFO, 64'h55, 9'h0);
        rd_chk("rstrd.prime", A_SCR, 64'hDEAD_BEEF_CAFE_F00D);
        rst = 1'b1;
        xact(1'b0, 1'b1, A_FIFO, 64'h0, 9'h09);
        rst = 1'b0;
        chk("rstrd.rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rstrd.rsp_data", rsp_data, 64'h0);
        chk("rstrd.rsp_tid", 64'(rsp_tid), 64'h0);
        chk("rstrd.not_empty", 64'(fifo_not_empty), 64'h0);
        chk("rstrd.full", 64'(fifo_full), 64'h0);
        rd_chk("rstrd.status", A_STS, 64'h0000_0008_0001_0000);
        rd_chk("rstrd.scratch", A_SCR, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
